// File: rtl/alu_rs_if.sv
// Issue, CDB and dispatch signals between the decoder/CDB side and the ALU
// reservation station.
interface alu_rs_if;
  logic        issue_valid;
  logic [5:0]  issue_op_type;
  logic [31:0] issue_vj;
  logic [31:0] issue_vk;
  logic        issue_qj_valid;
  logic        issue_qk_valid;
  logic [3:0]  issue_qj;
  logic [3:0]  issue_qk;
  logic [3:0]  issue_rob_dest;

  logic        cdb_alu_valid;
  logic [3:0]  cdb_alu_tag;
  logic [31:0] cdb_alu_value;
  logic        cdb_lsb_valid;
  logic [3:0]  cdb_lsb_tag;
  logic [31:0] cdb_lsb_value;

  logic        rs_full;
  logic        alu_mission;
  logic [5:0]  alu_op_type;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0]  alu_rob_dest;

  modport master (
    output issue_valid, issue_op_type, issue_vj, issue_vk, issue_qj_valid, issue_qk_valid,
           issue_qj, issue_qk, issue_rob_dest,
           cdb_alu_valid, cdb_alu_tag, cdb_alu_value, cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value,
    input  rs_full, alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest
  );

  modport slave (
    input  issue_valid, issue_op_type, issue_vj, issue_vk, issue_qj_valid, issue_qk_valid,
           issue_qj, issue_qk, issue_rob_dest,
           cdb_alu_valid, cdb_alu_tag, cdb_alu_value, cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_value,
    output rs_full, alu_mission, alu_op_type, alu_rs1, alu_rs2, alu_rob_dest
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ALU ops until both operands are known,
// snoops the ALU and LSB result buses, and dispatches one ready op per cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     rob_clear,
  alu_rs_if.slave  bus
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        qj_valid;
    logic [3:0]  qj;
    logic        qk_valid;
    logic [3:0]  qk;
    logic [3:0]  dest;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IdxW-1:0]    free_idx;
  logic [IdxW-1:0]    sel_idx;
  logic               full;
  logic               any_ready;

  logic        alu_mission_q, alu_mission_d;
  logic [5:0]  alu_op_type_q, alu_op_type_d;
  logic [31:0] alu_rs1_q, alu_rs1_d;
  logic [31:0] alu_rs2_q, alu_rs2_d;
  logic [3:0]  alu_rob_dest_q, alu_rob_dest_d;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] resolve(
    input logic        pend,
    input logic [3:0]  tag,
    input logic [31:0] val,
    input logic        a_valid,
    input logic [3:0]  a_tag,
    input logic [31:0] a_value,
    input logic        l_valid,
    input logic [3:0]  l_tag,
    input logic [31:0] l_value
  );
    if (!pend) return {1'b0, val};
    if (a_valid && (a_tag == tag)) return {1'b0, a_value};
    if (l_valid && (l_tag == tag)) return {1'b0, l_value};
    return {1'b1, val};
  endfunction

  // Lowest free entry for allocation and lowest ready entry for dispatch, from registered state.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_valid && !ent_q[i].qk_valid;
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i]) free_idx = IdxW'(i);
      if (ready_vec[i]) sel_idx = IdxW'(i);
    end
    full      = &busy_vec;
    any_ready = |ready_vec;
  end

  assign bus.rs_full = full;

  // Next entry state: wakeup, then dispatch release, then allocation into a pre-edge free slot.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_d[i].qj_valid, ent_d[i].vj} = resolve(ent_q[i].qj_valid, ent_q[i].qj, ent_q[i].vj,
            bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
            bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value);
        {ent_d[i].qk_valid, ent_d[i].vk} = resolve(ent_q[i].qk_valid, ent_q[i].qk, ent_q[i].vk,
            bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
            bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value);
      end
    end
    if (any_ready) ent_d[sel_idx].busy = 1'b0;
    // A free slot is never the selected one, so allocation cannot collide with dispatch.
    if (bus.issue_valid && !full) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op   = bus.issue_op_type;
      ent_d[free_idx].qj   = bus.issue_qj;
      ent_d[free_idx].qk   = bus.issue_qk;
      ent_d[free_idx].dest = bus.issue_rob_dest;
      {ent_d[free_idx].qj_valid, ent_d[free_idx].vj} = resolve(bus.issue_qj_valid, bus.issue_qj,
          bus.issue_vj, bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
          bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value);
      {ent_d[free_idx].qk_valid, ent_d[free_idx].vk} = resolve(bus.issue_qk_valid, bus.issue_qk,
          bus.issue_vk, bus.cdb_alu_valid, bus.cdb_alu_tag, bus.cdb_alu_value,
          bus.cdb_lsb_valid, bus.cdb_lsb_tag, bus.cdb_lsb_value);
    end
  end

  // Dispatch outputs: load the selected entry, otherwise drop mission and hold the payload.
  always_comb begin
    alu_mission_d  = any_ready;
    alu_op_type_d  = alu_op_type_q;
    alu_rs1_d      = alu_rs1_q;
    alu_rs2_d      = alu_rs2_q;
    alu_rob_dest_d = alu_rob_dest_q;
    if (any_ready) begin
      alu_op_type_d  = ent_q[sel_idx].op;
      alu_rs1_d      = ent_q[sel_idx].vj;
      alu_rs2_d      = ent_q[sel_idx].vk;
      alu_rob_dest_d = ent_q[sel_idx].dest;
    end
  end

  // State update: reset beats flush, flush beats the rdy stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_mission_q  <= 1'b0;
      alu_op_type_q  <= '0;
      alu_rs1_q      <= '0;
      alu_rs2_q      <= '0;
      alu_rob_dest_q <= '0;
    end else if (rob_clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      alu_mission_q <= 1'b0;
    end else if (!rdy) begin
      // Entries hold; mission drops so a finished op is not reported twice.
      alu_mission_q <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_mission_q  <= alu_mission_d;
      alu_op_type_q  <= alu_op_type_d;
      alu_rs1_q      <= alu_rs1_d;
      alu_rs2_q      <= alu_rs2_d;
      alu_rob_dest_q <= alu_rob_dest_d;
    end
  end

  assign bus.alu_mission  = alu_mission_q;
  assign bus.alu_op_type  = alu_op_type_q;
  assign bus.alu_rs1      = alu_rs1_q;
  assign bus.alu_rs2      = alu_rs2_q;
  assign bus.alu_rob_dest = alu_rob_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs with hand-computed dispatch expectations.
module tb_alu_rs;

  logic clk;
  logic rst;
  logic rdy;
  logic rob_clear;
  int   checks;
  int   failures;

  alu_rs_if bus ();

  alu_rs #(.RS_SIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rob_clear (rob_clear),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid    = 1'b0;
    bus.issue_op_type  = '0;
    bus.issue_vj       = '0;
    bus.issue_vk       = '0;
    bus.issue_qj_valid = 1'b0;
    bus.issue_qk_valid = 1'b0;
    bus.issue_qj       = '0;
    bus.issue_qk       = '0;
    bus.issue_rob_dest = '0;
    bus.cdb_alu_valid  = 1'b0;
    bus.cdb_alu_tag    = '0;
    bus.cdb_alu_value  = '0;
    bus.cdb_lsb_valid  = 1'b0;
    bus.cdb_lsb_tag    = '0;
    bus.cdb_lsb_value  = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjv, input logic [3:0] qj, input logic qkv,
                       input logic [3:0] qk, input logic [3:0] dest);
    bus.issue_valid    = 1'b1;
    bus.issue_op_type  = op;
    bus.issue_vj       = vj;
    bus.issue_vk       = vk;
    bus.issue_qj_valid = qjv;
    bus.issue_qj       = qj;
    bus.issue_qk_valid = qkv;
    bus.issue_qk       = qk;
    bus.issue_rob_dest = dest;
  endtask

  task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_tag   = tag;
    bus.cdb_alu_value = val;
  endtask

  task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_lsb_valid = 1'b1;
    bus.cdb_lsb_tag   = tag;
    bus.cdb_lsb_value = val;
  endtask

  task automatic chk_disp(input string tag, input logic [5:0] op, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [3:0] dest);
    chk({tag, "_mission"}, 32'(bus.alu_mission), 32'd1);
    chk({tag, "_op"}, 32'(bus.alu_op_type), 32'(op));
    chk({tag, "_rs1"}, bus.alu_rs1, rs1);
    chk({tag, "_rs2"}, bus.alu_rs2, rs2);
    chk({tag, "_dest"}, 32'(bus.alu_rob_dest), 32'(dest));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    rdy       = 1'b1;
    rob_clear = 1'b0;
    idle();
    step();
    chk("rst_full", 32'(bus.rs_full), 32'd0);
    chk("rst_mission", 32'(bus.alu_mission), 32'd0);
    chk("rst_op", 32'(bus.alu_op_type), 32'd0);
    chk("rst_rs1", bus.alu_rs1, 32'd0);
    chk("rst_rs2", bus.alu_rs2, 32'd0);
    chk("rst_dest", 32'(bus.alu_rob_dest), 32'd0);
    rst = 1'b0;
    step();

    // Ready ADD: inserted at one edge, dispatched the next, mission drops after.
    issue(6'd28, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step();
    idle();
    chk("add_ins_mission", 32'(bus.alu_mission), 32'd0);
    step();
    chk_disp("add", 6'd28, 32'd5, 32'd7, 4'd3);
    step();
    chk("add_drop_mission", 32'(bus.alu_mission), 32'd0);
    chk("add_hold_rs1", bus.alu_rs1, 32'd5);

    // SUB waiting on tag 4, woken from the LSB bus.
    issue(6'd29, 32'd0, 32'd2, 1'b1, 4'd4, 1'b0, 4'd0, 4'd1);
    step();
    idle();
    step();
    chk("sub_wait_mission", 32'(bus.alu_mission), 32'd0);
    lsb_bc(4'd4, 32'd10);
    step();
    idle();
    chk("sub_wake_mission", 32'(bus.alu_mission), 32'd0);
    step();
    chk_disp("sub", 6'd29, 32'd10, 32'd2, 4'd1);

    // Insert bypass; ALU bus wins over LSB bus on the same tag.
    issue(6'd33, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd2);
    alu_bc(4'd6, 32'd9);
    lsb_bc(4'd6, 32'h55);
    step();
    idle();
    step();
    chk_disp("bypass", 6'd33, 32'd9, 32'd1, 4'd2);
    step();

    // Fill all 8 entries, each blocked on qj = own index (tag 0 included).
    for (int i = 0; i < 8; i++) begin
      issue(6'd28, 32'd0, 32'(i * 16), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
      step();
    end
    idle();
    chk("fill_full", 32'(bus.rs_full), 32'd1);
    chk("fill_mission", 32'(bus.alu_mission), 32'd0);
    issue(6'd37, 32'hAA, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    step();
    idle();
    step();
    chk("ninth_ignored", 32'(bus.alu_mission), 32'd0);
    alu_bc(4'd2, 32'h22);
    step();
    idle();
    chk("wake2_full", 32'(bus.rs_full), 32'd1);
    step();
    chk_disp("e2", 6'd28, 32'h22, 32'h20, 4'd2);
    chk("e2_notfull", 32'(bus.rs_full), 32'd0);
    issue(6'd36, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step();
    idle();
    chk("reuse_full", 32'(bus.rs_full), 32'd1);
    step();
    chk_disp("reuse", 6'd36, 32'd3, 32'd4, 4'd9);
    chk("reuse_notfull", 32'(bus.rs_full), 32'd0);

    // Entries 1 and 5 ready together: lower index first.
    alu_bc(4'd1, 32'h11);
    lsb_bc(4'd5, 32'h55);
    step();
    idle();
    step();
    chk_disp("pri1", 6'd28, 32'h11, 32'h10, 4'd1);
    step();
    chk_disp("pri5", 6'd28, 32'h55, 32'h50, 4'd5);
    step();
    chk("pri_drop", 32'(bus.alu_mission), 32'd0);

    // Entry with both operands pending lands in slot 1.
    issue(6'd30, 32'd0, 32'd0, 1'b1, 4'd10, 1'b1, 4'd11, 4'd12);
    step();
    idle();

    // Entry 3 becomes ready, then rdy low for 3 cycles while tag 4 broadcasts.
    alu_bc(4'd3, 32'h33);
    step();
    idle();
    rdy = 1'b0;
    alu_bc(4'd4, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frozen_mission", 32'(bus.alu_mission), 32'd0);
    end
    idle();
    rdy = 1'b1;
    step();
    chk_disp("resume3", 6'd28, 32'h33, 32'h30, 4'd3);
    step();
    chk("frozen_cdb_ignored", 32'(bus.alu_mission), 32'd0);

    // Both operands wake in one cycle from different buses.
    alu_bc(4'd10, 32'hA0);
    lsb_bc(4'd11, 32'hB0);
    step();
    idle();
    step();
    chk_disp("both", 6'd30, 32'hA0, 32'hB0, 4'd12);

    // Busy now: entries 0, 4, 6, 7. Entry 4 ready, then flush with issue and wakeup.
    alu_bc(4'd4, 32'h44);
    step();
    idle();
    rob_clear = 1'b1;
    issue(6'd28, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    alu_bc(4'd6, 32'h66);
    step();
    rob_clear = 1'b0;
    idle();
    chk("clr_mission", 32'(bus.alu_mission), 32'd0);
    chk("clr_full", 32'(bus.rs_full), 32'd0);
    alu_bc(4'd0, 32'h1);
    lsb_bc(4'd7, 32'h7);
    step();
    idle();
    chk("clr_after1", 32'(bus.alu_mission), 32'd0);
    step();
    chk("clr_after2", 32'(bus.alu_mission), 32'd0);

    // Reset mid-operation discards a ready entry.
    issue(6'd31, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    step();
    idle();
    rst = 1'b1;
    step();
    chk("mrst_mission", 32'(bus.alu_mission), 32'd0);
    chk("mrst_op", 32'(bus.alu_op_type), 32'd0);
    chk("mrst_rs1", bus.alu_rs1, 32'd0);
    rst = 1'b0;
    step();
    chk("mrst_discard", 32'(bus.alu_mission), 32'd0);
    chk("mrst_full", 32'(bus.rs_full), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
